demapper: RTL and testbench
===========================

# demapper

Receive-side counterpart of the transmit mapper. Accepts the byte stream from the serial receiver, finds and tracks frame alignment on the FAS pattern, and strips overhead. It checks the per-frame CRC-8 and forwards payload bytes to the client TX AXIS FIFO with an end-of-frame marker and error flag. On a CRC mismatch it requests a retransmission from the far-end mapper.

## Interface
- `COLS`, default 1024: bytes per row, 8..2047. Frame is 4 rows × `COLS` bytes.
- `OH_COLS`, default 4: overhead columns at the start of each row, 2..`COLS`-2.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset. Asynchronous assert, active-high.
- `i_frame_data`  in  8  line byte from the serial receiver.
- `i_frame_data_valid`  in  1  `i_frame_data` valid this cycle.
- `o_pyld_data`  out  8  payload byte to the client TX FIFO.
- `o_pyld_data_valid`  out  1  payload byte strobe, AXIS tvalid.
- `o_pyld_last`  out  1  last payload byte of the frame.
- `o_pyld_err`  out  1  qualifies `o_pyld_last`: the frame failed CRC.
- `i_tx_fifo_ready`  in  1  client FIFO ready.
- `o_line_retrans_req`  out  1  1-cycle retransmission request pulse.
- `o_in_sync`  out  1  sync FSM is in SYNC.
- `o_crc_err`  out  1  CRC result of the most recent completed frame, 1 = bad.
- `o_ovf`  out  1  sticky: a payload byte was dropped because the FIFO was not ready.

## Operation
- **Frame layout**
  - Row 0, col 0 = 0xF6; row 0, col 1 = 0x28 (FAS).
  - Other overhead columns are reserved and ignored.
  - Payload = cols `OH_COLS`..`COLS`-1 of every row, except row 3, col `COLS`-1, which is the CRC byte.
  - Payload bytes per frame = 4·(`COLS`−`OH_COLS`)−1; 4079 at default parameters.
- **CRC-8**
  - Polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Computed over payload bytes only, in order.
  - Reset to 0x00 at each row 0, col 0.
- **Position counters** (row 2 b, col 11 b) advance only on `i_frame_data_valid`. Col wraps at `COLS`-1 to 0 and increments row; row wraps 3 to 0.
- **Sync FSM**
  - HUNT: scans the input for 0xF6 immediately followed by valid 0x28. On a hit, load the position as row 0, col 1, then go to PRESYNC. A non-matching second byte re-tests itself as a possible 0xF6.
  - PRESYNC: at the next row 0, col 0/1, both bytes match → SYNC, otherwise → HUNT. No payload is output.
  - SYNC: payload is forwarded and FAS is checked every frame. A mismatch in either byte increments a miss counter; a full match clears it. Two consecutive misses → HUNT, decided at col 1.
- **Payload release**
  - One-byte hold register. Each accepted payload byte displaces the held byte to the output.
  - When the CRC byte arrives, the held byte is released with `o_pyld_last` = 1 and `o_pyld_err` = (received ≠ computed).
  - The same cycle sets `o_crc_err` to that result and pulses `o_line_retrans_req` if the CRC is bad.
- **Overflow**: if `i_tx_fifo_ready` = 0 when a byte is released, the byte is dropped (the last/err marker too), `o_ovf` sets, and CRC/retransmission behaviour is unchanged.
- **Leaving SYNC** clears the hold register without output. The final frame's CRC is never checked.

## Timing
- Reset values: all outputs 0; FSM = HUNT; counters, CRC, hold register and miss counter = 0.
- Payload byte Pi appears on `o_pyld_data` one cycle after the input cycle carrying Pi+1, or the CRC byte for the last byte.
- All outputs are registered. `o_pyld_data_valid` is asserted for exactly one cycle per byte.
- `o_line_retrans_req`, `o_pyld_last` and `o_pyld_err` coincide, one cycle after the CRC byte.
- Gaps in `i_frame_data_valid` stall everything; no state changes while valid = 0.
- `i_rst` mid-frame: immediate return to reset values. The held byte is lost, and no retransmission request is generated.

## Configuration
- `DEMAPPER_CRC_CHECK_EN` defined: CRC logic present, as above.
- Not defined:
  - No CRC logic; `o_pyld_err`, `o_crc_err` and `o_line_retrans_req` are tied to 0.
  - The CRC byte is still consumed and still triggers `o_pyld_last`.
  - Sync, payload and overflow behaviour are unchanged.

## Structure
- Shared include/package `framing_defs`:
  - FAS bytes 0xF6/0x28, row count 4, CRC polynomial 0x07, CRC init 0x00.
  - Sync FSM state encodings: HUNT/PRESYNC/SYNC.
  - Also used by the mapper side.
- Sub-module `crc8_byte`: combinational next-CRC from (crc, data byte), shared with the mapper's CRC path.

## Test plan
- Reset, then 3 clean frames (`COLS`=16, `OH_COLS`=4) preceded by 5 junk bytes:
  - `o_in_sync` rises at the FAS of frame 2.
  - Frame 2 outputs 47 bytes; the last has `o_pyld_last`=1 and `o_pyld_err`=0.
  - No `o_line_retrans_req`.
- Frame with one payload bit flipped:
  - `o_pyld_err`=1, `o_crc_err`=1 and a single `o_line_retrans_req` pulse on the same cycle.
  - The next clean frame clears `o_crc_err`.
- One corrupted FAS then a good FAS: stays in SYNC. Two consecutive bad FAS: `o_in_sync` falls at col 1 of the second, then re-acquires after 2 good frames.
- `i_tx_fifo_ready`=0 for 3 payload releases: 3 bytes missing from the output and `o_ovf`=1 until reset.
- `i_frame_data_valid` toggled 50% randomly: output byte sequence and CRC results identical to the gapless run.
- Assert `i_rst` at row 2 mid-frame: all outputs 0 next edge, then HUNT, and re-sync on following frames.

Source files
------------

// File: rtl/framing_defs.sv
// Framing constants and sync FSM encodings shared by the mapper and demapper.
package framing_defs;
   localparam logic [7:0] FAS0     = 8'hF6;
   localparam logic [7:0] FAS1     = 8'h28;
   localparam int         ROWS     = 4;
   localparam logic [7:0] CRC_POLY = 8'h07;
   localparam logic [7:0] CRC_INIT = 8'h00;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PRESYNC = 2'd1,
      SYNC    = 2'd2
   } sync_state_e;
endpackage

// File: rtl/demapper_if.sv
// Line-byte input, payload output and status bundle of the demapper.
interface demapper_if;
   logic [7:0] i_frame_data;
   logic       i_frame_data_valid;
   logic       i_tx_fifo_ready;
   logic [7:0] o_pyld_data;
   logic       o_pyld_data_valid;
   logic       o_pyld_last;
   logic       o_pyld_err;
   logic       o_line_retrans_req;
   logic       o_in_sync;
   logic       o_crc_err;
   logic       o_ovf;

   modport slave (
      input  i_frame_data, i_frame_data_valid, i_tx_fifo_ready,
      output o_pyld_data, o_pyld_data_valid, o_pyld_last, o_pyld_err,
             o_line_retrans_req, o_in_sync, o_crc_err, o_ovf
   );

   modport master (
      output i_frame_data, i_frame_data_valid, i_tx_fifo_ready,
      input  o_pyld_data, o_pyld_data_valid, o_pyld_last, o_pyld_err,
             o_line_retrans_req, o_in_sync, o_crc_err, o_ovf
   );
endinterface

// File: rtl/crc8_byte.sv
// One-byte CRC-8 step (MSB first, no reflection); shared with the mapper CRC path.
module crc8_byte
   import framing_defs::*;
(
   input  logic [7:0] crc,
   input  logic [7:0] data,
   output logic [7:0] crc_next
);
   always_comb begin
      crc_next = crc ^ data;
      for (int i = 0; i < 8; i++)
         crc_next = crc_next[7] ? ((crc_next << 1) ^ CRC_POLY) : (crc_next << 1);
   end
endmodule

// File: rtl/demapper.sv
// Receive demapper: FAS alignment, overhead strip, payload release with per-frame CRC-8.
// Optional CRC checking is enabled by defining DEMAPPER_CRC_CHECK_EN.
module demapper
   import framing_defs::*;
#(
   parameter int COLS    = 1024,
   parameter int OH_COLS = 4
) (
   input logic       i_clk,
   input logic       i_rst,
   demapper_if.slave bus
);
   sync_state_e state, state_n;
   logic [1:0]  row, miss, miss_n;
   logic [10:0] col;
   logic        prev_f6, fas0_ok, hold_vld;
   logic [7:0]  hold;
   logic [7:0]  pyld_data;
   logic        pyld_vld, pyld_last, pyld_err, retrans, in_sync, crc_err, ovf;

   logic       vld, at_c0, at_c1, is_crc, is_pyld, fas_ok, hunt_hit, stay_sync, rel, crc_bad;
   logic [7:0] din;

   assign vld      = bus.i_frame_data_valid;
   assign din      = bus.i_frame_data;
   assign at_c0    = (row == 2'd0) && (col == 11'd0);
   assign at_c1    = (row == 2'd0) && (col == 11'd1);
   assign is_crc   = (row == 2'(ROWS - 1)) && (col == 11'(COLS - 1));
   assign is_pyld  = (col >= 11'(OH_COLS)) && !is_crc;
   assign fas_ok   = fas0_ok && (din == FAS1);
   assign hunt_hit = prev_f6 && (din == FAS1);

`ifdef DEMAPPER_CRC_CHECK_EN
   logic [7:0] crc, crc_upd;

   crc8_byte u_crc (.crc(crc), .data(din), .crc_next(crc_upd));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)           crc <= CRC_INIT;
      else if (vld) begin
         if (at_c0)        crc <= CRC_INIT;
         else if (is_pyld) crc <= crc_upd;
      end
   end

   assign crc_bad = (din != crc);
`else
   assign crc_bad = 1'b0;
`endif

   always_comb begin
      state_n = state;
      miss_n  = miss;
      if (vld) begin
         case (state)
            HUNT:    if (hunt_hit) state_n = PRESYNC;
            PRESYNC: if (at_c1)    state_n = fas_ok ? SYNC : HUNT;
            SYNC: if (at_c1) begin
               if (fas_ok) miss_n = 2'd0;
               else if (miss == 2'd1) begin
                  state_n = HUNT;
                  miss_n  = 2'd0;
               end else miss_n = miss + 2'd1;
            end
            default: state_n = HUNT;
         endcase
      end
   end

   // Payload and CRC bytes never sit at col 1, so staying in SYNC is the only case that moves data.
   assign stay_sync = vld && (state == SYNC) && (state_n == SYNC);
   assign rel       = stay_sync && (is_pyld || is_crc) && hold_vld;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= HUNT;
         miss      <= 2'd0;
         row       <= 2'd0;
         col       <= 11'd0;
         prev_f6   <= 1'b0;
         fas0_ok   <= 1'b0;
         hold      <= 8'd0;
         hold_vld  <= 1'b0;
         pyld_data <= 8'd0;
         pyld_vld  <= 1'b0;
         pyld_last <= 1'b0;
         pyld_err  <= 1'b0;
         retrans   <= 1'b0;
         in_sync   <= 1'b0;
         crc_err   <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         pyld_vld  <= 1'b0;
         pyld_last <= 1'b0;
         pyld_err  <= 1'b0;
         retrans   <= 1'b0;
         if (vld) begin
            state   <= state_n;
            miss    <= miss_n;
            in_sync <= (state_n == SYNC);
            prev_f6 <= (din == FAS0);
            if (at_c0) fas0_ok <= (din == FAS0);

            // A hunt hit marks the current byte as row 0, col 1.
            if (state == HUNT && hunt_hit) begin
               row <= 2'd0;
               col <= 11'd2;
            end else if (col == 11'(COLS - 1)) begin
               col <= 11'd0;
               row <= (row == 2'(ROWS - 1)) ? 2'd0 : row + 2'd1;
            end else col <= col + 11'd1;

            if (state == SYNC && state_n != SYNC) hold_vld <= 1'b0;
            else if (stay_sync && is_pyld) begin
               hold     <= din;
               hold_vld <= 1'b1;
            end else if (stay_sync && is_crc) begin
               hold_vld <= 1'b0;
               crc_err  <= crc_bad;
               retrans  <= crc_bad;
            end

            if (rel) begin
               if (bus.i_tx_fifo_ready) begin
                  pyld_data <= hold;
                  pyld_vld  <= 1'b1;
                  pyld_last <= is_crc;
                  pyld_err  <= is_crc && crc_bad;
               end else ovf <= 1'b1;
            end
         end
      end
   end

   assign bus.o_pyld_data        = pyld_data;
   assign bus.o_pyld_data_valid  = pyld_vld;
   assign bus.o_pyld_last        = pyld_last;
   assign bus.o_pyld_err         = pyld_err;
   assign bus.o_line_retrans_req = retrans;
   assign bus.o_in_sync          = in_sync;
   assign bus.o_crc_err          = crc_err;
   assign bus.o_ovf              = ovf;
endmodule

// File: tb/tb_demapper.sv
// Directed bench for demapper at COLS=16, OH_COLS=4: sync, CRC, FAS loss, overflow, gaps, reset.
module tb_demapper;
   import framing_defs::*;

   localparam int COLS = 16;
   localparam int OH   = 4;
   localparam int NPL  = 4 * (COLS - OH) - 1;
`ifdef DEMAPPER_CRC_CHECK_EN
   localparam logic CRC_EN = 1'b1;
`else
   localparam logic CRC_EN = 1'b0;
`endif

   logic i_clk = 1'b0;
   logic i_rst;

   demapper_if bus();

   demapper #(.COLS(COLS), .OH_COLS(OH)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   int         n_run  = 0;
   int         n_fail = 0;
   int         rt_cnt = 0;
   int         rt_coinc = 0;
   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];
   logic       sync_c0, sync_c1;

   always @(negedge i_clk) begin
      if (bus.o_pyld_data_valid)
         got_q.push_back({bus.o_pyld_last, bus.o_pyld_err, bus.o_pyld_data});
      if (bus.o_line_retrans_req) begin
         rt_cnt <= rt_cnt + 1;
         if (bus.o_pyld_data_valid && bus.o_pyld_last && bus.o_pyld_err) rt_coinc <= rt_coinc + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      logic       fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[7] ^ d[i];
         r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return r;
   endfunction

   function automatic logic [7:0] pbyte(input int fid, input int k);
      return 8'((fid * 5 + k * 3) & 127);
   endfunction

   task automatic drive(input logic [7:0] b, input logic rdy);
      @(negedge i_clk);
      bus.i_frame_data       = b;
      bus.i_frame_data_valid = 1'b1;
      bus.i_tx_fifo_ready    = rdy;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge i_clk);
         bus.i_frame_data_valid = 1'b0;
         bus.i_tx_fifo_ready    = 1'b1;
      end
   endtask

   // flip_k < 0: no corruption; bytes k in [drop_k, drop_k+2] are released with ready low.
   task automatic send_frame(input int fid, input logic [7:0] fas0, input int flip_k,
                             input bit expect_out, input int drop_k, input bit gaps,
                             input int nbytes);
      logic [7:0] b, crc;
      int         k, rel_idx;
      logic       rdy;
      crc = 8'h00;
      k   = 0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (r * COLS + c >= nbytes) return;
            rel_idx = -1;
            if (r == 0 && c == 0)             b = fas0;
            else if (r == 0 && c == 1)        b = FAS1;
            else if (c < OH)                  b = 8'h00;
            else if (r == 3 && c == COLS - 1) begin
               b       = crc;
               rel_idx = NPL - 1;
            end else begin
               b   = pbyte(fid, k);
               crc = crc8(crc, b);
               if (k == flip_k) b = b ^ 8'h10;
               rel_idx = k - 1;
               if (expect_out && !(k >= drop_k && k < drop_k + 3)) begin
                  if (k == NPL - 1) exp_q.push_back({1'b1, CRC_EN && (flip_k >= 0), b});
                  else              exp_q.push_back({2'b00, b});
               end
               k++;
            end
            rdy = !(rel_idx >= 0 && rel_idx >= drop_k && rel_idx < drop_k + 3);
            drive(b, rdy);
            if (r == 0 && c == 1) sync_c0 = bus.o_in_sync;
            if (r == 0 && c == 2) sync_c1 = bus.o_in_sync;
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
         end
      end
   endtask

   task automatic cmp_out(input string tag);
      chk({tag, "_cnt"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] junk[5];
      junk = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      bus.i_frame_data       = 8'h00;
      bus.i_frame_data_valid = 1'b0;
      bus.i_tx_fifo_ready    = 1'b1;
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("rst_valid",   bus.o_pyld_data_valid, 0);
      chk("rst_data",    bus.o_pyld_data, 0);
      chk("rst_last",    bus.o_pyld_last, 0);
      chk("rst_err",     bus.o_pyld_err, 0);
      chk("rst_retrans", bus.o_line_retrans_req, 0);
      chk("rst_sync",    bus.o_in_sync, 0);
      chk("rst_crc_err", bus.o_crc_err, 0);
      chk("rst_ovf",     bus.o_ovf, 0);
      i_rst = 1'b0;

      // acquisition: junk, presync frame, then frames 2 and 3 forwarded
      foreach (junk[i]) drive(junk[i], 1'b1);
      send_frame(1, FAS0, -1, 0, -100, 0, 64);
      chk("f1_presync", sync_c1, 0);
      send_frame(2, FAS0, -1, 1, -100, 0, 64);
      chk("f2_sync_c0", sync_c0, 0);
      chk("f2_sync_c1", sync_c1, 1);
      send_frame(3, FAS0, -1, 1, -100, 0, 64);
      idle(2);
      cmp_out("clean");
      chk("clean_retrans", rt_cnt, 0);
      chk("clean_crc_err", bus.o_crc_err, 0);

      send_frame(4, FAS0, 20, 1, -100, 0, 64);
      idle(2);
      cmp_out("flip");
      chk("flip_crc_err", bus.o_crc_err, CRC_EN);
      chk("flip_retrans", rt_cnt, CRC_EN);
      chk("flip_coinc",   rt_coinc, CRC_EN);
      send_frame(5, FAS0, -1, 1, -100, 0, 64);
      idle(2);
      chk("clear_crc_err", bus.o_crc_err, 0);
      cmp_out("after_flip");

      // FAS loss: single miss tolerated, two consecutive misses drop sync
      send_frame(6, 8'h00, -1, 1, -100, 0, 64);
      chk("miss1_sync", sync_c1, 1);
      send_frame(7, FAS0, -1, 1, -100, 0, 64);
      chk("good_sync", sync_c1, 1);
      send_frame(8, 8'h00, -1, 1, -100, 0, 64);
      chk("miss_a_sync", sync_c1, 1);
      send_frame(9, 8'h00, -1, 0, -100, 0, 64);
      chk("miss_b_c0", sync_c0, 1);
      chk("miss_b_c1", sync_c1, 0);
      send_frame(10, FAS0, -1, 0, -100, 0, 64);
      chk("reacq_pre", sync_c1, 0);
      send_frame(11, FAS0, -1, 1, -100, 0, 64);
      chk("reacq_sync", sync_c1, 1);
      idle(2);
      cmp_out("fas");
      chk("pre_ovf", bus.o_ovf, 0);

      send_frame(12, FAS0, -1, 1, 10, 0, 64);
      idle(2);
      cmp_out("drop");
      chk("ovf_set", bus.o_ovf, 1);

      // same content as frames 3/4, valid toggled randomly
      send_frame(3, FAS0, -1, 1, -100, 1, 64);
      send_frame(4, FAS0, 20, 1, -100, 1, 64);
      idle(2);
      cmp_out("gaps");
      chk("gaps_crc_err", bus.o_crc_err, CRC_EN);
      chk("gaps_retrans", rt_cnt, 2 * CRC_EN);
      chk("ovf_sticky",   bus.o_ovf, 1);

      // reset at row 2, col 5 with a byte held
      send_frame(13, FAS0, -1, 0, -100, 0, 2 * COLS + 5);
      @(negedge i_clk);
      bus.i_frame_data_valid = 1'b0;
      i_rst = 1'b1;
      #1;
      chk("mid_rst_valid", bus.o_pyld_data_valid, 0);
      chk("mid_rst_sync",  bus.o_in_sync, 0);
      chk("mid_rst_ovf",   bus.o_ovf, 0);
      chk("mid_rst_crc",   bus.o_crc_err, 0);
      got_q.delete();
      exp_q.delete();
      @(negedge i_clk);
      i_rst = 1'b0;
      send_frame(14, FAS0, -1, 0, -100, 0, 64);
      chk("rst_hunt_pre", sync_c1, 0);
      send_frame(15, FAS0, -1, 1, -100, 0, 64);
      chk("rst_resync", sync_c1, 1);
      idle(2);
      cmp_out("resync");
      chk("resync_retrans", rt_cnt, 2 * CRC_EN);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
